// File: rtl/seven_seg_decoder_if.sv
// Multiplexed 7-segment bus plus the decoded results seen by the receive-side monitor.
// The master side drives the anode/cathode lines; the slave side is the decoder.
interface seven_seg_decoder_if #(
  parameter int NUM_DIGITS = 8
);
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_done;
  logic [15:0]             frame_count;
  logic                    pattern_err;
  logic                    anode_err;
  logic                    display_lost;

  modport master (
    output an, seg,
    input  digits, digit_valid, frame_done, frame_count, pattern_err, anode_err, display_lost
  );

  modport slave (
    input  an, seg,
    output digits, digit_valid, frame_done, frame_count, pattern_err, anode_err, display_lost
  );
endinterface

// File: rtl/seven_seg_decoder.sv
// Passive monitor for a multiplexed 7-segment display bus (active-low anodes and cathodes).
// Synchronises the bus, waits for a stable window, decodes the lit digit into a shadow
// register and reports frame completion, bus faults and loss of refresh.
// Optional feature: define SEVEN_SEG_HEX_EN to accept the A..F glyphs as good digits.
module seven_seg_decoder #(
  parameter int NUM_DIGITS     = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  seven_seg_decoder_if.slave  bus
);
  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [SW-1:0]           sync1, sync2;
  logic [CW-1:0]           settle_cnt;
  logic [TW-1:0]           tout_cnt;
  logic [NUM_DIGITS-1:0]   seen, seen_nxt;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   digit_valid_q;
  logic                    frame_done_q, pattern_err_q, anode_err_q, display_lost_q;
  logic [15:0]             frame_count_q;

  logic [NUM_DIGITS-1:0]   cap_an;
  logic [6:0]              cap_seg;
  logic                    capture, cap_one_hot, cap_multi, timeout_hit, seen_full;
  logic [IW-1:0]           idx;
  logic [4:0]              dec;      // {good, code}
  logic                    dec_blank;

  // Segment pattern (g..a, active-low) to {good, code}; unknown patterns map to error code F.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0011000: decode = 5'h19;
`ifdef SEVEN_SEG_HEX_EN
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
`endif
      default:    decode = 5'h0F;
    endcase
  endfunction

  assign cap_an      = sync2[SW-1:7];
  assign cap_seg     = sync2[6:0];
  // The sample about to enter sync2 equals the current one: the window is still stable.
  assign capture     = (sync1 == sync2) && (settle_cnt == SETTLE_LAST);
  assign cap_one_hot = capture && $onehot(~cap_an);
  assign cap_multi   = capture && (~cap_an != '0) && !$onehot(~cap_an);
  assign timeout_hit = !cap_one_hot && (tout_cnt == TOUT_LAST);
  assign seen_full   = (seen == '1);
  assign dec         = decode(cap_seg);
  assign dec_blank   = (cap_seg == 7'h7F);

  // Locate the single low anode; only meaningful when cap_one_hot is set.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!cap_an[i]) idx = IW'(i);
  end

  // Next seen-mask: a full mask clears, a timeout clears, a one-hot capture marks its digit.
  always_comb begin
    seen_nxt = seen_full ? '0 : seen;
    if (cap_one_hot)      seen_nxt[idx] = 1'b1;
    else if (timeout_hit) seen_nxt = '0;
  end

  // Two-flop synchroniser for the asynchronous bus and the stability counter.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1      <= '0;
      sync2      <= '0;
      settle_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1 <= {bus.an, bus.seg};
      sync2 <= sync1;
      if (sync1 != sync2)              settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Capture handling: shadow register, error pulses, frame tracking and refresh timeout.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      digits_q       <= '0;
      digit_valid_q  <= '0;
      seen           <= '0;
      tout_cnt       <= '0;
      frame_done_q   <= 1'b0;
      frame_count_q  <= '0;
      pattern_err_q  <= 1'b0;
      anode_err_q    <= 1'b0;
      display_lost_q <= 1'b0;
    end else begin
      seen          <= seen_nxt;
      frame_done_q  <= seen_full;
      if (seen_full) frame_count_q <= frame_count_q + 16'd1;
      pattern_err_q <= 1'b0;
      anode_err_q   <= cap_multi;
      if (cap_one_hot) begin
        tout_cnt       <= '0;
        display_lost_q <= 1'b0;
        digit_valid_q[idx] <= dec[4];
        if (dec[4]) begin
          digits_q[4*idx +: 4] <= dec[3:0];
        end else if (!dec_blank) begin
          digits_q[4*idx +: 4] <= 4'hF;
          pattern_err_q        <= 1'b1;
        end
      end else begin
        if (tout_cnt != TOUT_MAX) tout_cnt <= tout_cnt + 1'b1;
        if (timeout_hit) begin
          display_lost_q <= 1'b1;
          digit_valid_q  <= '0;
        end
      end
    end
  end

  assign bus.digits       = digits_q;
  assign bus.digit_valid  = digit_valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_count  = frame_count_q;
  assign bus.pattern_err  = pattern_err_q;
  assign bus.anode_err    = anode_err_q;
  assign bus.display_lost = display_lost_q;
endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed bench for seven_seg_decoder: reset state, capture latency, frame scan,
// a table of decode/fault vectors, glitch rejection, refresh timeout and async reset.
module tb_seven_seg_decoder;
  localparam int ND = 8;

`ifdef SEVEN_SEG_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic CLK100MHZ = 1'b0;
  logic CPU_RESETN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0, perr_cnt = 0, aerr_cnt = 0;

  seven_seg_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_decoder #(
    .NUM_DIGITS(ND), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .bus       (bus)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Pulse counters sampled mid-cycle.
  always @(negedge CLK100MHZ) begin
    if (CPU_RESETN) begin
      if (bus.frame_done)  fd_cnt++;
      if (bus.pattern_err) perr_cnt++;
      if (bus.anode_err)   aerr_cnt++;
    end
  end

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    int         idx;
    logic [3:0] code;
    logic       valid;
    int         perr;
    int         aerr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK100MHZ);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg);
    bus.an  = an;
    bus.seg = seg;
  endtask

  task automatic do_reset();
    CPU_RESETN = 1'b0;
    drive(8'hFF, 7'h7F);
    #22;
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    tick();
  endtask

  function automatic logic [3:0] nib(input logic [31:0] d, input int i);
    return d[4*i +: 4];
  endfunction

  logic [6:0] scan_seg[8];
  int f0, p0, a0;

  initial begin
    scan_seg = '{7'b0010010, 7'b0110000, 7'b0000010, 7'b1111000,
                 7'b1000000, 7'b1111001, 7'b0100100, 7'b0011000};

    vecs[0]  = '{8'b11111100, 7'b0000000, 0, 4'h5, 1'b1, 0, 1};
    vecs[1]  = '{8'b11111011, 7'b0000001, 2, 4'hF, 1'b0, 1, 0};
    vecs[2]  = '{8'b11111101, 7'b0001000, 1, HEX ? 4'hA : 4'hF, HEX, HEX ? 0 : 1, 0};
    vecs[3]  = '{8'b11110111, 7'b0000000, 3, 4'h8, 1'b1, 0, 0};
    vecs[4]  = '{8'b11101111, 7'b0011001, 4, 4'h4, 1'b1, 0, 0};
    vecs[5]  = '{8'b11101111, 7'b1111111, 4, 4'h4, 1'b0, 0, 0};
    vecs[6]  = '{8'b11011111, 7'b0000110, 5, HEX ? 4'hE : 4'hF, HEX, HEX ? 0 : 1, 0};
    vecs[7]  = '{8'b10111111, 7'b1111111, 6, 4'h2, 1'b0, 0, 0};
    vecs[8]  = '{8'b11111111, 7'b0000001, 2, 4'hF, 1'b0, 0, 0};
    vecs[9]  = '{8'b01111111, 7'b0100001, 7, HEX ? 4'hD : 4'hF, HEX, HEX ? 0 : 1, 0};
    vecs[10] = '{8'b11111110, 7'b0000011, 0, HEX ? 4'hB : 4'hF, HEX, HEX ? 0 : 1, 0};
    vecs[11] = '{8'b11111011, 7'b1000110, 2, HEX ? 4'hC : 4'hF, HEX, HEX ? 0 : 1, 0};
    vecs[12] = '{8'b10111111, 7'b0001110, 6, 4'hF, HEX, HEX ? 0 : 1, 0};
    vecs[13] = '{8'b11111101, 7'b0100100, 1, 4'h2, 1'b1, 0, 0};

    // Reset state
    do_reset();
    check("rst_digits", bus.digits, 32'h0);
    check("rst_valid", {24'h0, bus.digit_valid}, 32'h0);
    check("rst_frame_done", {31'h0, bus.frame_done}, 32'h0);
    check("rst_frame_count", {16'h0, bus.frame_count}, 32'h0);
    check("rst_pattern_err", {31'h0, bus.pattern_err}, 32'h0);
    check("rst_anode_err", {31'h0, bus.anode_err}, 32'h0);
    check("rst_display_lost", {31'h0, bus.display_lost}, 32'h0);

    // Capture latency: update lands on the sixth edge after the change
    drive(8'b11111110, 7'b0010010);
    tick(5);
    check("lat_edge5_valid", {31'h0, bus.digit_valid[0]}, 32'h0);
    tick();
    check("lat_edge6_digit", {28'h0, nib(bus.digits, 0)}, 32'h5);
    check("lat_edge6_valid", {24'h0, bus.digit_valid}, 32'h01);
    tick(4);
    check("lat_hold_digits", bus.digits, 32'h5);

    // Full scan of eight digits, then a second scan to show the frame boundary
    do_reset();
    f0 = fd_cnt;
    for (int d = 0; d < ND; d++) begin
      drive(~(8'h01 << d), scan_seg[d]);
      tick(8);
    end
    drive(8'hFF, 7'h7F);
    tick(8);
    check("scan_fd_pulses", fd_cnt - f0, 1);
    check("scan_frame_count", {16'h0, bus.frame_count}, 32'h1);
    check("scan_digits", bus.digits, 32'h92107635);
    check("scan_valid", {24'h0, bus.digit_valid}, 32'hFF);
    for (int d = 0; d < ND - 1; d++) begin
      drive(~(8'h01 << d), scan_seg[d]);
      tick(8);
    end
    check("scan2_partial_count", {16'h0, bus.frame_count}, 32'h1);
    drive(8'h7F, scan_seg[7]);
    tick(8);
    check("scan2_full_count", {16'h0, bus.frame_count}, 32'h2);
    check("scan2_fd_pulses", fd_cnt - f0, 2);

    // Table of decode and fault vectors
    for (int v = 0; v < 14; v++) begin
      p0 = perr_cnt;
      a0 = aerr_cnt;
      drive(vecs[v].an, vecs[v].seg);
      tick(8);
      check($sformatf("vec%0d_code", v), {28'h0, nib(bus.digits, vecs[v].idx)}, {28'h0, vecs[v].code});
      check($sformatf("vec%0d_valid", v), {31'h0, bus.digit_valid[vecs[v].idx]}, {31'h0, vecs[v].valid});
      check($sformatf("vec%0d_perr", v), perr_cnt - p0, vecs[v].perr);
      check($sformatf("vec%0d_aerr", v), aerr_cnt - a0, vecs[v].aerr);
    end

    // Glitching cathodes shorter than the settle window never capture
    p0 = perr_cnt;
    a0 = aerr_cnt;
    for (int g = 0; g < 10; g++) begin
      drive(8'b11110111, g[0] ? 7'b0110000 : 7'b1111001);
      tick(3);
    end
    drive(8'hFF, 7'h7F);
    tick(8);
    check("glitch_digit3", {28'h0, nib(bus.digits, 3)}, 32'h8);
    check("glitch_valid3", {31'h0, bus.digit_valid[3]}, 32'h1);
    check("glitch_errs", (perr_cnt - p0) + (aerr_cnt - a0), 0);

    // Refresh timeout, recovery and asynchronous reset
    do_reset();
    drive(8'b11111110, 7'b0010010);
    tick(6);
    check("to_capture", {24'h0, bus.digit_valid}, 32'h01);
    tick(63);
    check("to_before", {31'h0, bus.display_lost}, 32'h0);
    tick();
    check("to_lost", {31'h0, bus.display_lost}, 32'h1);
    check("to_valid_cleared", {24'h0, bus.digit_valid}, 32'h0);
    check("to_digits_kept", bus.digits, 32'h5);
    drive(8'b11111101, 7'b0110000);
    tick(5);
    check("resume_still_lost", {31'h0, bus.display_lost}, 32'h1);
    tick();
    check("resume_lost_drop", {31'h0, bus.display_lost}, 32'h0);
    check("resume_digits", bus.digits, 32'h35);
    check("resume_valid", {24'h0, bus.digit_valid}, 32'h02);
    drive(8'b11111011, 7'b0000010);
    tick(3);
    CPU_RESETN = 1'b0;
    #1;
    check("async_rst_digits", bus.digits, 32'h0);
    check("async_rst_valid", {24'h0, bus.digit_valid}, 32'h0);
    check("async_rst_lost", {31'h0, bus.display_lost}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
